// File: rtl/div16_unit.sv
`default_nettype none
// ============================================================================
// Module   : div16_unit
// Purpose  : Sequential unsigned divider (restoring, shift-subtract, one
//            quotient bit per clock). It responds to the controller's divide
//            handshake. A one-cycle `load` latches the operands. `done` rises
//            WIDTH cycles later and stays high, with quotient/remainder held,
//            until the next `load` or `rst`.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            dividend  - [WIDTH-1:0] dividend, sampled when load=1
//            divisor   - [WIDTH-1:0] divisor, sampled when load=1
//            load      - start pulse; restarts from any state
//            quotient  - [WIDTH-1:0] registered quotient, updated at completion
//            remainder - [WIDTH-1:0] registered remainder, updated at completion
//            done      - registered; high while a completed result is held
// Revision : 1.0 - initial release
// ============================================================================
module div16_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             load,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_ITER = CW'(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  // After every iteration the partial remainder is below the divisor.
  // Its top bit of the 17-bit form is therefore always zero, so only the
  // low WIDTH bits are stored.
  logic [WIDTH-1:0] part_q,  part_d;
  logic [WIDTH-1:0] wq_q,    wq_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             done_q,  done_d;

  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   trial_w;
  logic [WIDTH-1:0] part_nxt_w;
  logic [WIDTH-1:0] wq_nxt_w;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (cnt_q == C_LAST) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // The shift moves the working quotient's MSB into the partial remainder.
    shift_w    = {part_q, wq_q[WIDTH-1]};
    trial_w    = shift_w - {1'b0, dvs_q};
    // A borrow (MSB set) means the trial went negative. In that case keep
    // the shifted value instead of the difference. The restored value always
    // fits in WIDTH bits.
    part_nxt_w = trial_w[WIDTH] ? shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
    wq_nxt_w   = {wq_q[WIDTH-2:0], ~trial_w[WIDTH]};

    cnt_d  = cnt_q;
    part_d = part_q;
    wq_d   = wq_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    done_d = done_q;

    if (load) begin
      wq_d   = dividend;
      dvs_d  = divisor;
      part_d = '0;
      cnt_d  = C_ITER;
      done_d = 1'b0;
    end else if (state_q == S_RUN) begin
      part_d = part_nxt_w;
      wq_d   = wq_nxt_w;
      cnt_d  = cnt_q - C_LAST;
      if (cnt_q == C_LAST) begin
        quot_d = wq_nxt_w;
        rem_d  = part_nxt_w;
        done_d = 1'b1;
      end
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_div16_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div16_unit
// Purpose  : Self-checking bench for div16_unit. It drives directed operand
//            vectors with hand-computed results, then a back-to-back sweep
//            checked against / and %.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div16_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        load;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Result the outputs must keep holding until the next completion.
  logic [15:0] hold_q = 16'h0;
  logic [15:0] hold_r = 16'h0;

  div16_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .dividend  (dividend),
    .divisor   (divisor),
    .load      (load),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands and pulses load for one edge (E0). Returns #1 after E0.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    load     = 1'b1;
    @(posedge clk); #1;
    load     = 1'b0;
    chk("done_cleared_at_load", {31'd0, done}, 32'd0);
  endtask

  // Waits (bounded) for done, scrambling the operand inputs every cycle.
  // Checks that the previous result is held while busy, then checks
  // latency, quotient and remainder.
  task automatic wait_done(input logic [15:0] eq, input logic [15:0] er, input string tag);
    int lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      if (done !== 1'b1) begin
        chk({tag, "_hold_q"}, {16'd0, quotient},  {16'd0, hold_q});
        chk({tag, "_hold_r"}, {16'd0, remainder}, {16'd0, hold_r});
      end
    end
    chk({tag, "_latency"},   lat,                  32'd16);
    chk({tag, "_quotient"},  {16'd0, quotient},  {16'd0, eq});
    chk({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
    hold_q = eq;
    hold_r = er;
  endtask

  initial begin
    logic [15:0] a, b, eq, er;
    rst      = 1'b1;
    load     = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;

    // Reset held 2 cycles, then idle 5 cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_done", {31'd0, done},       32'd0);
      chk("reset_q",    {16'd0, quotient},   32'd0);
      chk("reset_r",    {16'd0, remainder},  32'd0);
    end

    // Basic divide, then confirm the result holds with no load.
    start(16'd100, 16'd7);
    wait_done(16'd14, 16'd2, "basic");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("basic_hold_done", {31'd0, done},      32'd1);
      chk("basic_hold_q",    {16'd0, quotient},  32'd14);
      chk("basic_hold_r",    {16'd0, remainder}, 32'd2);
    end

    // Extremes and divide-by-zero. Each load lands in the first DONE cycle.
    start(16'hFFFF, 16'd1);    wait_done(16'hFFFF, 16'd0,    "ffff_div_1");
    start(16'd5,    16'd9);    wait_done(16'd0,    16'd5,    "5_div_9");
    start(16'hFFFF, 16'hFFFF); wait_done(16'd1,    16'd0,    "ffff_div_ffff");
    start(16'd1234, 16'd0);    wait_done(16'hFFFF, 16'd1234, "div_by_zero");

    // A restart during RUN aborts the first operation. Only the second
    // operation's result may appear.
    start(16'd1000, 16'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("restart_busy_done", {31'd0, done}, 32'd0);
    end
    start(16'd50, 16'd5);
    wait_done(16'd10, 16'd0, "restart");
    @(posedge clk); #1;
    chk("restart_single_done", {31'd0, done},     32'd1);
    chk("restart_final_q",     {16'd0, quotient}, 32'd10);

    // Reset asserted mid-operation, sampled at iteration 8.
    start(16'd40000, 16'd7);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_done", {31'd0, done},      32'd0);
    chk("midrst_q",    {16'd0, quotient},  32'd0);
    chk("midrst_r",    {16'd0, remainder}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_idle_done", {31'd0, done}, 32'd0);
    hold_q = 16'd0;
    hold_r = 16'd0;

    // Back-to-back sweep against the / and % reference.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      if (i % 4 == 0)      b = 16'($urandom_range(0, 20));
      else if (i % 4 == 1) b = 16'($urandom_range(0, 255));
      else                 b = 16'($urandom);
      if (b == 16'd0) begin
        eq = 16'hFFFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      start(a, b);
      wait_done(eq, er, "sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
